// File: rtl/cva6_lsu_model_pkg.sv
// Shared constants, entry type and pointer-wrap helper for the multi-outstanding
// CVA6 LSU reference model.
package cva6_lsu_model_pkg;

    localparam int unsigned LQ_DEPTH_DEF = 4;
    localparam int unsigned SQ_DEPTH_DEF = 4;
    localparam int unsigned LSU_ADDR_W   = 12;

    typedef struct packed {
        logic                  valid;
        logic [LSU_ADDR_W-1:0] addr;
    } lsu_entry_t;

    // Explicit wrap so depths that are not a power of two still cycle correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        if (ptr >= depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cva6_lsu_model_fifo.sv
// In-order address queue with occupancy count and a flattened view of every
// entry so the owner can run an address match across the whole queue.
module cva6_lsu_model_fifo
    import cva6_lsu_model_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 12,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [W-1:0]       push_data_i,
    input  logic               pop_i,
    output logic [CNT_W-1:0]   count_o,
    output logic [W-1:0]       head_data_o,
    output logic [DEPTH-1:0]   valid_o,
    output logic [DEPTH*W-1:0] addr_flat_o
);

    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0][W-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    // The owner only pushes when not full and only pops when not empty,
    // so the write slot and the read slot never coincide in one cycle.
    always_comb begin
        valid_d  = valid_q;
        addr_d   = addr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = push_data_i;
            wr_ptr_d          = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            addr_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o     = count_q;
    assign head_data_o = addr_q[rd_ptr_q];
    assign valid_o     = valid_q;
    assign addr_flat_o = addr_q;

endmodule

// File: rtl/cva6_lsu_model_mq.sv
// LSU reference model tracking several outstanding loads and stores in two
// independent in-order queues, with an optional store-to-load address stall.
module cva6_lsu_model_mq
    import cva6_lsu_model_pkg::*;
#(
    parameter int unsigned LQ_DEPTH  = LQ_DEPTH_DEF,
    parameter int unsigned SQ_DEPTH  = SQ_DEPTH_DEF,
    parameter int unsigned ADDR_W    = LSU_ADDR_W,
    parameter bit          HAZARD_EN = 1'b1,
    localparam int unsigned LQ_CNT_W = $clog2(LQ_DEPTH + 1),
    localparam int unsigned SQ_CNT_W = $clog2(SQ_DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         instr_i,
    input  logic                is_load_i,
    input  logic                instr_valid_i,
    input  logic                load_mem_resp_i,
    input  logic                store_mem_resp_i,
    output logic                ready_o,
    output logic [LQ_CNT_W-1:0] lq_count_o,
    output logic [SQ_CNT_W-1:0] sq_count_o,
    output logic                load_done_o,
    output logic [ADDR_W-1:0]   load_done_addr_o,
    output logic                store_done_o,
    output logic [ADDR_W-1:0]   store_done_addr_o,
    output logic                protocol_err_o
);

    logic [ADDR_W-1:0]          req_addr_s;
    logic [LQ_CNT_W-1:0]        lq_count_s;
    logic [SQ_CNT_W-1:0]        sq_count_s;
    logic [ADDR_W-1:0]          lq_head_s, sq_head_s;
    logic [SQ_DEPTH-1:0]        sq_valid_s;
    logic [SQ_DEPTH*ADDR_W-1:0] sq_addr_s;
    logic [LQ_DEPTH-1:0]        lq_unused_valid_s;
    logic [LQ_DEPTH*ADDR_W-1:0] lq_unused_addr_s;
    logic                       unused_instr_s;
    logic                       hit_s, hazard_s, ready_s;
    logic                       lq_push_s, sq_push_s, lq_pop_s, sq_pop_s;
    logic                       lq_empty_s, sq_empty_s;

    logic                       load_done_q, load_done_d;
    logic                       store_done_q, store_done_d;
    logic [ADDR_W-1:0]          load_done_addr_q, load_done_addr_d;
    logic [ADDR_W-1:0]          store_done_addr_q, store_done_addr_d;
    logic                       err_q, err_d;

    assign req_addr_s     = instr_i[ADDR_W-1:0];
    assign unused_instr_s = ^instr_i[31:ADDR_W];

    // Conservative match: a store retiring this cycle still blocks the load.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            hit_s = hit_s | (sq_valid_s[i] & (sq_addr_s[i*ADDR_W +: ADDR_W] == req_addr_s));
        end
        hazard_s = HAZARD_EN & hit_s;
    end

    // Ready, accept and retire decode; ready uses the pre-retire counts.
    always_comb begin
        lq_empty_s = (lq_count_s == LQ_CNT_W'(0));
        sq_empty_s = (sq_count_s == SQ_CNT_W'(0));
        if (is_load_i) begin
            ready_s = (lq_count_s < LQ_CNT_W'(LQ_DEPTH)) & ~hazard_s;
        end else begin
            ready_s = (sq_count_s < SQ_CNT_W'(SQ_DEPTH));
        end
        lq_push_s = instr_valid_i & ready_s & is_load_i;
        sq_push_s = instr_valid_i & ready_s & ~is_load_i;
        lq_pop_s  = load_mem_resp_i & ~lq_empty_s;
        sq_pop_s  = store_mem_resp_i & ~sq_empty_s;
    end

    assign ready_o = ready_s;

    cva6_lsu_model_fifo #(.DEPTH(LQ_DEPTH), .W(ADDR_W)) u_lq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (lq_push_s),
        .push_data_i (req_addr_s),
        .pop_i       (lq_pop_s),
        .count_o     (lq_count_s),
        .head_data_o (lq_head_s),
        .valid_o     (lq_unused_valid_s),
        .addr_flat_o (lq_unused_addr_s)
    );

    cva6_lsu_model_fifo #(.DEPTH(SQ_DEPTH), .W(ADDR_W)) u_sq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (sq_push_s),
        .push_data_i (req_addr_s),
        .pop_i       (sq_pop_s),
        .count_o     (sq_count_s),
        .head_data_o (sq_head_s),
        .valid_o     (sq_valid_s),
        .addr_flat_o (sq_addr_s)
    );

    // Done pulses with the popped address; the error flag is sticky.
    always_comb begin
        load_done_d  = lq_pop_s;
        store_done_d = sq_pop_s;
        if (lq_pop_s) begin
            load_done_addr_d = lq_head_s;
        end else begin
            load_done_addr_d = load_done_addr_q;
        end
        if (sq_pop_s) begin
            store_done_addr_d = sq_head_s;
        end else begin
            store_done_addr_d = store_done_addr_q;
        end
        err_d = err_q | (load_mem_resp_i & lq_empty_s) | (store_mem_resp_i & sq_empty_s);
    end

    // Output register stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            load_done_q       <= 1'b0;
            store_done_q      <= 1'b0;
            load_done_addr_q  <= '0;
            store_done_addr_q <= '0;
            err_q             <= 1'b0;
        end else begin
            load_done_q       <= load_done_d;
            store_done_q      <= store_done_d;
            load_done_addr_q  <= load_done_addr_d;
            store_done_addr_q <= store_done_addr_d;
            err_q             <= err_d;
        end
    end

    assign lq_count_o        = lq_count_s;
    assign sq_count_o        = sq_count_s;
    assign load_done_o       = load_done_q;
    assign store_done_o      = store_done_q;
    assign load_done_addr_o  = load_done_addr_q;
    assign store_done_addr_o = store_done_addr_q;
    assign protocol_err_o    = err_q;

endmodule

// File: tb/tb_cva6_lsu_model_mq.sv
// Directed bench: instance a uses default depths with hazard checking, instance
// b uses depth 3 queues with hazard checking disabled.
module tb_cva6_lsu_model_mq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_rst, a_load, a_valid, a_lresp, a_sresp;
    logic [31:0] a_instr;
    logic        a_ready, a_ld_done, a_st_done, a_err;
    logic [2:0]  a_lq, a_sq;
    logic [11:0] a_ld_addr, a_st_addr;

    logic        b_rst, b_load, b_valid, b_lresp, b_sresp;
    logic [31:0] b_instr;
    logic        b_ready, b_ld_done, b_st_done, b_err;
    logic [1:0]  b_lq, b_sq;
    logic [11:0] b_ld_addr, b_st_addr;

    cva6_lsu_model_mq #(.LQ_DEPTH(4), .SQ_DEPTH(4), .ADDR_W(12), .HAZARD_EN(1'b1)) u_a (
        .clk_i             (clk),
        .rst_i             (a_rst),
        .instr_i           (a_instr),
        .is_load_i         (a_load),
        .instr_valid_i     (a_valid),
        .load_mem_resp_i   (a_lresp),
        .store_mem_resp_i  (a_sresp),
        .ready_o           (a_ready),
        .lq_count_o        (a_lq),
        .sq_count_o        (a_sq),
        .load_done_o       (a_ld_done),
        .load_done_addr_o  (a_ld_addr),
        .store_done_o      (a_st_done),
        .store_done_addr_o (a_st_addr),
        .protocol_err_o    (a_err)
    );

    cva6_lsu_model_mq #(.LQ_DEPTH(3), .SQ_DEPTH(3), .ADDR_W(12), .HAZARD_EN(1'b0)) u_b (
        .clk_i             (clk),
        .rst_i             (b_rst),
        .instr_i           (b_instr),
        .is_load_i         (b_load),
        .instr_valid_i     (b_valid),
        .load_mem_resp_i   (b_lresp),
        .store_mem_resp_i  (b_sresp),
        .ready_o           (b_ready),
        .lq_count_o        (b_lq),
        .sq_count_o        (b_sq),
        .load_done_o       (b_ld_done),
        .load_done_addr_o  (b_ld_addr),
        .store_done_o      (b_st_done),
        .store_done_addr_o (b_st_addr),
        .protocol_err_o    (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_load = 1'b0; a_valid = 1'b0; a_lresp = 1'b0; a_sresp = 1'b0; a_instr = 32'h0;
        b_rst = 1'b1; b_load = 1'b0; b_valid = 1'b0; b_lresp = 1'b0; b_sresp = 1'b0; b_instr = 32'h0;
        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        a_load = 1'b1;
        #1;
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_lq", 32'(a_lq), 32'd0);
        chk("rst_sq", 32'(a_sq), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_ld_done", 32'(a_ld_done), 32'd0);
        chk("rst_ld_addr", 32'(a_ld_addr), 32'd0);

        // spurious load response on an empty queue
        a_lresp = 1'b1;
        step();
        a_lresp = 1'b0;
        chk("spur_err", 32'(a_err), 32'd1);
        chk("spur_done", 32'(a_ld_done), 32'd0);
        chk("spur_lq", 32'(a_lq), 32'd0);
        step();
        chk("spur_done2", 32'(a_ld_done), 32'd0);
        chk("spur_err_sticky", 32'(a_err), 32'd1);

        // fill the load queue
        a_valid = 1'b1;
        a_load  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_instr = 32'h0A0 + 32'(i);
            step();
        end
        a_valid = 1'b0;
        a_instr = 32'h0A4;
        #1;
        chk("full_lq", 32'(a_lq), 32'd4);
        chk("full_ready_load", 32'(a_ready), 32'd0);
        a_load  = 1'b0;
        a_instr = 32'h100;
        #1;
        chk("full_ready_store", 32'(a_ready), 32'd1);
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("store_sq", 32'(a_sq), 32'd1);
        chk("store_lq", 32'(a_lq), 32'd4);

        // in-order retire on consecutive response cycles
        a_lresp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("retire_done", 32'(a_ld_done), 32'd1);
            chk("retire_addr", 32'(a_ld_addr), 32'h0A0 + 32'(i));
            chk("retire_lq", 32'(a_lq), 32'(3 - i));
        end
        a_lresp = 1'b0;
        step();
        chk("retire_idle", 32'(a_ld_done), 32'd0);

        // store-to-load hazard
        a_load  = 1'b0;
        a_instr = 32'hCAD;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("haz_sq", 32'(a_sq), 32'd2);
        a_load = 1'b1;
        #1;
        chk("haz_ready_same", 32'(a_ready), 32'd0);
        a_instr = 32'hCAE;
        #1;
        chk("haz_ready_other", 32'(a_ready), 32'd1);
        a_sresp = 1'b1;
        step();
        chk("haz_st_done1", 32'(a_st_done), 32'd1);
        chk("haz_st_addr1", 32'(a_st_addr), 32'h100);
        a_instr = 32'hCAD;
        #1;
        chk("haz_ready_retiring", 32'(a_ready), 32'd0);
        step();
        a_sresp = 1'b0;
        chk("haz_st_addr2", 32'(a_st_addr), 32'hCAD);
        chk("haz_sq0", 32'(a_sq), 32'd0);
        #1;
        chk("haz_ready_cleared", 32'(a_ready), 32'd1);
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("haz_load_accepted", 32'(a_lq), 32'd1);

        // both response strobes in one cycle
        a_load  = 1'b0;
        a_instr = 32'h055;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        a_lresp = 1'b1;
        a_sresp = 1'b1;
        step();
        a_lresp = 1'b0;
        a_sresp = 1'b0;
        chk("both_ld_done", 32'(a_ld_done), 32'd1);
        chk("both_ld_addr", 32'(a_ld_addr), 32'hCAD);
        chk("both_st_done", 32'(a_st_done), 32'd1);
        chk("both_st_addr", 32'(a_st_addr), 32'h055);
        chk("both_lq", 32'(a_lq), 32'd0);
        chk("both_sq", 32'(a_sq), 32'd0);

        // push and pop on the same queue in one cycle
        a_load  = 1'b1;
        a_instr = 32'h011;
        a_valid = 1'b1;
        step();
        a_instr = 32'h012;
        a_lresp = 1'b1;
        step();
        a_valid = 1'b0;
        chk("pp_lq", 32'(a_lq), 32'd1);
        chk("pp_addr1", 32'(a_ld_addr), 32'h011);
        step();
        a_lresp = 1'b0;
        chk("pp_addr2", 32'(a_ld_addr), 32'h012);
        chk("pp_lq0", 32'(a_lq), 32'd0);
        step();
        chk("pp_idle", 32'(a_ld_done), 32'd0);
        chk("pp_no_err", 32'(a_err), 32'd1);

        // reset clears the sticky error
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        chk("rst_err_clear", 32'(a_err), 32'd0);
        chk("rst_ld_addr_clear", 32'(a_ld_addr), 32'd0);

        // hazard disabled: matching load accepted immediately
        b_load  = 1'b0;
        b_instr = 32'hCAD;
        b_valid = 1'b1;
        step();
        b_load = 1'b1;
        #1;
        chk("nohaz_ready", 32'(b_ready), 32'd1);
        step();
        b_valid = 1'b0;
        chk("nohaz_lq", 32'(b_lq), 32'd1);
        chk("nohaz_sq", 32'(b_sq), 32'd1);
        b_lresp = 1'b1;
        b_sresp = 1'b1;
        step();
        b_lresp = 1'b0;
        b_sresp = 1'b0;
        chk("nohaz_drain_lq", 32'(b_lq), 32'd0);
        chk("nohaz_drain_sq", 32'(b_sq), 32'd0);

        // full store queue plus retire in the same cycle does not accept
        b_load  = 1'b0;
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_instr = 32'h201 + 32'(i);
            step();
        end
        b_instr = 32'h204;
        b_sresp = 1'b1;
        #1;
        chk("sqfull_cnt", 32'(b_sq), 32'd3);
        chk("sqfull_ready", 32'(b_ready), 32'd0);
        step();
        b_sresp = 1'b0;
        chk("sqfull_retire_cnt", 32'(b_sq), 32'd2);
        chk("sqfull_retire_addr", 32'(b_st_addr), 32'h201);
        #1;
        chk("sqfull_ready_again", 32'(b_ready), 32'd1);
        step();
        b_valid = 1'b0;
        chk("sqfull_accept", 32'(b_sq), 32'd3);
        b_sresp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sq_drain_addr", 32'(b_st_addr), 32'h202 + 32'(i));
        end
        b_sresp = 1'b0;
        step();
        chk("sq_drain_cnt", 32'(b_sq), 32'd0);

        // pointer wrap: six overlapped push/pop pairs on a depth-3 queue
        b_load  = 1'b1;
        b_valid = 1'b1;
        b_instr = 32'h300;
        step();
        b_lresp = 1'b1;
        for (int i = 1; i < 6; i++) begin
            b_instr = 32'h300 + 32'(i);
            step();
            chk("wrap_addr", 32'(b_ld_addr), 32'h300 + 32'(i - 1));
            chk("wrap_lq", 32'(b_lq), 32'd1);
        end
        b_valid = 1'b0;
        step();
        b_lresp = 1'b0;
        chk("wrap_last_addr", 32'(b_ld_addr), 32'h305);
        chk("wrap_lq0", 32'(b_lq), 32'd0);
        chk("wrap_no_err", 32'(b_err), 32'd0);

        // reset with two loads pending
        b_valid = 1'b1;
        b_instr = 32'h400;
        step();
        b_instr = 32'h401;
        step();
        b_valid = 1'b0;
        chk("midrst_lq2", 32'(b_lq), 32'd2);
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        chk("midrst_lq0", 32'(b_lq), 32'd0);
        chk("midrst_done", 32'(b_ld_done), 32'd0);
        step();
        chk("midrst_done2", 32'(b_ld_done), 32'd0);
        chk("midrst_lq_hold", 32'(b_lq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cva6_lsu_model_mq.md
# cva6_lsu_model_mq

Parametrised successor to the single-outstanding CVA6 LSU behavioural model: it tracks up to `LQ_DEPTH` in-flight loads and `SQ_DEPTH` in-flight stores in two independent in-order queues. Loads and stores are retired by separate memory-response strobes. An optional store-to-load address hazard check stalls a load that targets an address with a pending store. It sits beside the LSU shim in the lifting bench as the reference model whose `ready_o` is compared cycle-by-cycle.

## Interface
- `LQ_DEPTH`, 4: load queue entries, 1..16, not required to be a power of 2
- `SQ_DEPTH`, 4: store queue entries, 1..16
- `ADDR_W`, 12: address bits taken from `instr_i[ADDR_W-1:0]`, stored and compared
- `HAZARD_EN`, 1: 1 enables store-to-load address stall; 0 disables it
- `clk_i` in 1: single clock, all state on rising edge
- `rst_i` in 1: synchronous, active-high reset
- `instr_i` in 32: instruction/address; low `ADDR_W` bits used
- `is_load_i` in 1: 1 = load, 0 = store; qualifies `instr_i`
- `instr_valid_i` in 1: request valid
- `load_mem_resp_i` in 1: retire oldest load
- `store_mem_resp_i` in 1: retire oldest store
- `ready_o` out 1: request accepted this cycle if `instr_valid_i`
- `lq_count_o` out $clog2(LQ_DEPTH+1): valid load entries
- `sq_count_o` out $clog2(SQ_DEPTH+1): valid store entries
- `load_done_o` out 1: one-cycle pulse, load retired
- `load_done_addr_o` out ADDR_W: address of that retired load
- `store_done_o` out 1: one-cycle pulse, store retired
- `store_done_addr_o` out ADDR_W: address of that retired store
- `protocol_err_o` out 1: sticky; set on a response to an empty queue

## Operation
- **Ready:**
  - `ready_o = is_load_i ? (lq_count < LQ_DEPTH && !hazard) : (sq_count < SQ_DEPTH)`.
  - `ready_o` is combinational from `is_load_i`/`instr_i` and current state. It is independent of `instr_valid_i`.
- **Hazard:**
  - Asserted when `HAZARD_EN` and any valid store entry's address equals `instr_i[ADDR_W-1:0]`.
  - Includes an entry retiring in the same cycle. The check is conservative, with no bypass.
- **Accept:** `instr_valid_i && ready_o` writes the address at the tail of the selected queue. The tail advances and the count increments.
- **Retire:**
  - A response strobe with count>0 pops the head and the head advances.
  - The registered done pulse and popped address appear next cycle.
- **Spurious response:** a strobe with count==0 is ignored (no pop, no done pulse) and sets `protocol_err_o`. Only reset clears it.
- **Simultaneous accept and retire, same queue:** count unchanged, both pointers advance.
  - Full queue plus retire in the same cycle does not accept. Ready uses the pre-retire count.
- **Both response strobes in one cycle:** both queues retire independently.
- **Pointer wrap:** pointers wrap from DEPTH-1 to 0 explicitly (non-power-of-2 safe).
- Queues hold no per-entry state beyond address and valid.

## Timing
- **Reset:**
  - All counts 0, pointers 0, entries invalid.
  - `load_done_o`/`store_done_o`/`protocol_err_o` 0; done addresses 0.
  - `ready_o` 1 (queues empty, no hazard).
  - Reset asserted mid-operation discards all entries at the next edge with no done pulses.
- **Accept to visibility:**
  - Accept at edge N makes the count and hazard visible in cycle N+1.
  - Load-after-store to the same address is stalled from N+1 onward.
- **Response to done:** a response sampled at edge N drives `done_o` high for exactly cycle N+1, with the address. The count drops in N+1.
- **Minimum residency:** an entry accepted at edge N can be retired by a response sampled at edge N+1 at the earliest.

## Structure
- **Package `cva6_lsu_model_pkg`:**
  - Default depth/width constants.
  - Function `ptr_inc(ptr, depth)` implementing the wrap.
  - `lsu_entry_t` parameterised via `ADDR_W` localparam: {valid, addr}.
- **Sub-module `cva6_lsu_model_fifo`:**
  - Parameters DEPTH, W.
  - Push/pop, count, head data, and a flattened entry-valid/address vector for the hazard CAM.
  - Instantiated twice.
- The top holds ready/hazard logic, done registers and the error flag.

## Test plan
- **Reset/idle:**
  - After `rst_i` high 2 cycles then low: `ready_o`=1 and counts 0.
  - Lone `load_mem_resp_i` pulse: `protocol_err_o`=1, `load_done_o` never 1.
- **Fill load queue (depth 4):**
  - Four loads at 0x0A0–0x0A3: `lq_count_o`=4 and `ready_o`=0 for a load.
  - A store is still accepted (`sq_count_o`=1).
- **In-order retire:** the four loads, then four `load_mem_resp_i` pulses, produce `load_done_addr_o` 0x0A0, 0x0A1, 0x0A2, 0x0A3 in consecutive cycles after each pulse.
- **Hazard:**
  - Store 0xCAD accepted; load 0xCAD gives `ready_o`=0. Load 0xCAE gives `ready_o`=1.
  - After `store_mem_resp_i`, in the next cycle load 0xCAD gives `ready_o`=1.
  - With `HAZARD_EN`=0, load 0xCAD is accepted immediately.
- **Full plus simultaneous retire, SQ_DEPTH=3:**
  - With 3 stores, a store request together with `store_mem_resp_i` is not accepted (`sq_count_o`=2 next cycle).
  - Next cycle the store is accepted (`sq_count_o`=3).
- **Wrap and reset mid-flight, LQ_DEPTH=3:**
  - Six push/pop pairs: done addresses match push order.
  - `rst_i` pulse with 2 loads pending: counts 0 next cycle, no `load_done_o`.
